ram_write_arb: RTL and testbench

Per-bank write arbiter between the direction-to-bank write-command fan-out and one RAM bank's single write port. Each bank receives up to four candidate write commands per cycle, one per direction (west, east, south, north; south already merges linefill). This block picks one with a round-robin grant and buffers it in a small FIFO. It then presents it to the RAM with a valid/ready handshake. Eight instances exist, one per RAM bank.

---
 rtl/ram_write_arb_if.sv | 17 +
 rtl/ram_write_arb.sv | 151 +++++++++++++++
 tb/tb_ram_write_arb.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_write_arb_if.sv
// Write-command payload type and the valid/ready/payload channel used on
// every port of ram_write_arb (four direction candidates and the RAM side).
package ram_write_arb_pkg;
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } write_ram_pld_t;
endpackage

interface ram_write_arb_if;
  logic                             vld;
  logic                             rdy;
  ram_write_arb_pkg::write_ram_pld_t pld;

  modport master (output vld, output pld, input rdy);
  modport slave  (input vld, input pld, output rdy);
endinterface

// File: rtl/ram_write_arb.sv
// Per-bank write arbiter: round-robin over west/east/south/north, small command FIFO.
// Optional macro WR_ARB_SOUTH_PRIO_EN gives south absolute priority over the rotation.
module ram_write_arb
  import ram_write_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  ram_write_arb_if.slave              west_wr,
  ram_write_arb_if.slave              east_wr,
  ram_write_arb_if.slave              south_wr,
  ram_write_arb_if.slave              north_wr,
  ram_write_arb_if.master             ram_wr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]     req_vld;
  logic [3:0]     req_rdy;
  logic [3:0]     rr_vld;
  write_ram_pld_t req_pld [4];

  logic [1:0] ptr_reg;
  logic [1:0] rr_grant;
  logic [1:0] grant;
  logic [1:0] ptr_next;
  logic       any_vld;
  logic       fifo_full;
  logic       push;
  logic       pop;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  write_ram_pld_t   mem_reg [FIFO_DEPTH];

  assign req_vld = {north_wr.vld, south_wr.vld, east_wr.vld, west_wr.vld};
  assign req_pld[0] = west_wr.pld;
  assign req_pld[1] = east_wr.pld;
  assign req_pld[2] = south_wr.pld;
  assign req_pld[3] = north_wr.pld;

  assign west_wr.rdy  = req_rdy[0];
  assign east_wr.rdy  = req_rdy[1];
  assign south_wr.rdy = req_rdy[2];
  assign north_wr.rdy = req_rdy[3];

`ifdef WR_ARB_SOUTH_PRIO_EN
  // South is handled outside the rotation, so the pointer never lands on it.
  assign rr_vld = req_vld & 4'b1011;
`else
  assign rr_vld = req_vld;
`endif

  always_comb begin : rr_search
    logic [1:0] idx;
    logic       found;
    rr_grant = ptr_reg;
    found    = 1'b0;
    idx      = ptr_reg;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_reg + 2'(k);
      if (!found && rr_vld[idx]) begin
        rr_grant = idx;
        found    = 1'b1;
      end
    end
  end

`ifdef WR_ARB_SOUTH_PRIO_EN
  assign grant = req_vld[2] ? 2'd2 : rr_grant;
`else
  assign grant = rr_grant;
`endif

  always_comb begin
    ptr_next = grant + 2'd1;
`ifdef WR_ARB_SOUTH_PRIO_EN
    if (ptr_next == 2'd2) begin
      ptr_next = 2'd3;
    end
`endif
  end

  assign any_vld   = |req_vld;
  assign fifo_full = (cnt_reg >= CNT_W'(FIFO_DEPTH));
  // No full pass-through: a pop in the same cycle does not free a slot for a push.
  assign push      = any_vld && !fifo_full && !rst;
  assign pop       = (cnt_reg != '0) && ram_wr.rdy;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rdy
      assign req_rdy[gi] = push && (grant == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 2'd0;
    end else if (push) begin
`ifdef WR_ARB_SOUTH_PRIO_EN
      if (grant != 2'd2) begin
        ptr_reg <= ptr_next;
      end
`else
      ptr_reg <= ptr_next;
`endif
    end
  end

  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= req_pld[grant];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
        2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign ram_wr.vld = (cnt_reg != '0);
  assign ram_wr.pld = mem_reg[rd_ptr_reg];
  assign fifo_cnt   = cnt_reg;

endmodule

// File: tb/tb_ram_write_arb.sv
// Directed bench for ram_write_arb: grant vectors checked inline, RAM-side
// payload order checked by a scoreboard monitor. Honours WR_ARB_SOUTH_PRIO_EN.
module tb_ram_write_arb;
  import ram_write_arb_pkg::*;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_write_arb_if west_if ();
  ram_write_arb_if east_if ();
  ram_write_arb_if south_if ();
  ram_write_arb_if north_if ();
  ram_write_arb_if ram_if ();

  logic [3:0]       vld;
  write_ram_pld_t   pld [4];
  logic             ram_rdy;
  logic [CNT_W-1:0] fifo_cnt;
  logic [3:0]       rdy_vec;

  assign west_if.vld  = vld[0];
  assign east_if.vld  = vld[1];
  assign south_if.vld = vld[2];
  assign north_if.vld = vld[3];
  assign west_if.pld  = pld[0];
  assign east_if.pld  = pld[1];
  assign south_if.pld = pld[2];
  assign north_if.pld = pld[3];
  assign ram_if.rdy   = ram_rdy;
  assign rdy_vec = {north_if.rdy, south_if.rdy, east_if.rdy, west_if.rdy};

  ram_write_arb #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .west_wr  (west_if),
    .east_wr  (east_if),
    .south_wr (south_if),
    .north_wr (north_if),
    .ram_wr   (ram_if),
    .fifo_cnt (fifo_cnt)
  );

  int tests = 0;
  int fails = 0;
  write_ram_pld_t exp_q [$];
  int seq [4];
  int eseq [4];

  function automatic write_ram_pld_t mk(input int d, input int s);
    write_ram_pld_t p;
    p.addr = 8'(8'h10 * (d + 1) + s);
    p.data = 32'hA000_0000 | 32'(d << 8) | 32'(s);
    return p;
  endfunction

  function automatic logic [3:0] oh(input int d);
    return 4'(1 << d);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic grant_chk(input string name, input logic [3:0] req);
    #1;
    chk(name, rdy_vec, req);
  endtask

  task automatic expect_dir(input int d);
    exp_q.push_back(mk(d, eseq[d]));
    eseq[d]++;
  endtask

  // Advance one clock; any direction that was accepted presents its next payload.
  task automatic tick();
    logic [3:0] acc;
    #1;
    acc = rdy_vec & vld;
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      if (acc[d]) begin
        seq[d]++;
        pld[d] = mk(d, seq[d]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ram_if.vld && ram_rdy) begin
      $display("[TB] pop addr=%0h data=%0h", ram_if.pld.addr, ram_if.pld.data);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: actual=%0h required=none", ram_if.pld);
      end else begin
        chk("sb_pld", ram_if.pld, exp_q.pop_front());
      end
    end
  end

  initial begin
    int d;
    vld     = '0;
    ram_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq[i]  = 0;
      eseq[i] = 0;
      pld[i]  = mk(i, 0);
    end

    // Reset state, with all requests raised
    rst = 1'b1;
    vld = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    grant_chk("rst_rdy", 4'b0000);
    chk("rst_ram_vld", ram_if.vld, 0);
    chk("rst_ram_pld", ram_if.pld, 0);
    chk("rst_cnt", fifo_cnt, 0);
    vld     = '0;
    rst     = 1'b0;
    ram_rdy = 1'b1;

    // Single west request: same-cycle rdy, head valid next cycle
    vld = 4'b0001;
    grant_chk("t1_west", oh(0));
    expect_dir(0);
    tick();
    vld = '0;
    chk("t1_ram_vld", ram_if.vld, 1);
    chk("t1_ram_pld", ram_if.pld, mk(0, 0));
    chk("t1_cnt", fifo_cnt, 1);
    // Pointer now at east
    vld = 4'b0011;
    grant_chk("t1_ptr_east", oh(1));
    expect_dir(1);
    tick();
    grant_chk("t1_then_west", oh(0));
    expect_dir(0);
    tick();
    vld = '0;
    tick();

    // All four valid, starting from ptr=1
    vld = 4'hF;
    for (int i = 0; i < 8; i++) begin
`ifdef WR_ARB_SOUTH_PRIO_EN
      d = 2;
`else
      d = (i + 1) % 4;
`endif
      grant_chk("t2_grant", oh(d));
      expect_dir(d);
      tick();
      chk("t2_cnt_le1", fifo_cnt <= 1, 1);
    end
    vld = '0;
    tick();
    chk("t2_drained", fifo_cnt, 0);

    // Fill to full with RAM stalled, then drain
    ram_rdy = 1'b0;
    vld = 4'b0001;
    grant_chk("t3_push_a", oh(0));
    expect_dir(0);
    tick();
    grant_chk("t3_push_b", oh(0));
    expect_dir(0);
    tick();
    chk("t3_cnt2", fifo_cnt, 2);
    grant_chk("t3_full", 4'b0000);
    tick();
    grant_chk("t3_full_hold", 4'b0000);
    ram_rdy = 1'b1;
    grant_chk("t3_no_passthru", 4'b0000);
    tick();
    vld = '0;
    chk("t3_cnt1", fifo_cnt, 1);
    tick();
    chk("t3_cnt0", fifo_cnt, 0);

    // Simultaneous push and pop at occupancy 1
    ram_rdy = 1'b0;
    vld = 4'b0001;
    grant_chk("t4_push", oh(0));
    expect_dir(0);
    tick();
    chk("t4_cnt1", fifo_cnt, 1);
    ram_rdy = 1'b1;
    grant_chk("t4_push_pop", oh(0));
    expect_dir(0);
    tick();
    vld = '0;
    chk("t4_cnt_hold", fifo_cnt, 1);
    chk("t4_new_head", ram_if.pld, mk(0, eseq[0] - 1));
    tick();
    chk("t4_cnt0", fifo_cnt, 0);

    // South and north together (ptr=1), then west/east/north
    vld = 4'b1100;
    for (int i = 0; i < 4; i++) begin
`ifdef WR_ARB_SOUTH_PRIO_EN
      d = 2;
`else
      d = (i % 2 == 0) ? 2 : 3;
`endif
      grant_chk("t5_sn_grant", oh(d));
      expect_dir(d);
      tick();
    end
    vld = 4'b1011;
    for (int i = 0; i < 3; i++) begin
`ifdef WR_ARB_SOUTH_PRIO_EN
      d = (i == 0) ? 1 : ((i == 1) ? 3 : 0);
`else
      d = (i == 0) ? 0 : ((i == 1) ? 1 : 3);
`endif
      grant_chk("t5_wen_grant", oh(d));
      expect_dir(d);
      tick();
    end
    vld = '0;
    tick();

    // Move ptr away from 0, fill the FIFO, then reset mid-operation
    vld = 4'b0010;
    grant_chk("t6_east", oh(1));
    expect_dir(1);
    tick();
    vld = '0;
    tick();
    ram_rdy = 1'b0;
    vld = 4'b0001;
    grant_chk("t6_fill_a", oh(0));
    expect_dir(0);
    tick();
    grant_chk("t6_fill_b", oh(0));
    expect_dir(0);
    tick();
    chk("t6_cnt2", fifo_cnt, 2);
    exp_q.delete();
    rst = 1'b1;
    vld = 4'hF;
    grant_chk("t6_rst_rdy", 4'b0000);
    tick();
    chk("t6_rst_cnt", fifo_cnt, 0);
    chk("t6_rst_ram_vld", ram_if.vld, 0);
    grant_chk("t6_rst_rdy2", 4'b0000);
    rst = 1'b0;
    ram_rdy = 1'b1;
    grant_chk("t6_first_west", oh(0));
    expect_dir(0);
    tick();
`ifdef WR_ARB_SOUTH_PRIO_EN
    d = 2;
`else
    d = 1;
`endif
    grant_chk("t6_second", oh(d));
    expect_dir(d);
    tick();
    vld = '0;
    tick();
    tick();
    chk("t6_cnt0", fifo_cnt, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
